// File: rtl/fetch_pc_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_stage_pkg
// Description : Shared types and constants for the fetch PC stage: FSM state
//               encoding, fetched-entry record, reset PC default, word-PC
//               width and the word-to-byte address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_stage_pkg;

    // Word-PC width: byte PC bits [31:2]; the only supported value
    localparam int WORD_PC_W = 30;

    // Byte address of the first fetch after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // request may be presented to instruction memory
        ST_WAIT = 2'd1,   // one granted request, response pending
        ST_KILL = 2'd2    // one granted request whose response must be dropped
    } fetch_state_t;

    // One fetched instruction travelling toward decode
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_entry_t;

    // Convert a word PC into its byte address
    function automatic logic [31:0] word_to_addr(input logic [WORD_PC_W-1:0] word);
        return {word, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry skid buffer sitting behind the fetch output
//               register. Absorbs a response that arrives while decode is
//               stalled; flush discards the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pc_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         valid,
    output fetch_entry_t data
);

    logic         r_valid;
    fetch_entry_t r_data;

    // Occupancy: flush wins, a push refills even when popping the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (push) begin
            r_valid <= 1'b1;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    // Payload is only loaded on push; its contents are don't-care when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (push && !flush) begin
            r_data <= push_data;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_stage
// Description : Instruction fetch PC stage. Keeps the word PC, issues one
//               instruction-memory request at a time, captures the response
//               into a decode-facing output register and handles redirects
//               (discarding an in-flight response when needed). The word-PC
//               incrementer lives outside this block.
//               Build option: define FETCH_SKID_BUF_EN to add a one-entry skid
//               buffer behind the output register so fetching can continue
//               one instruction ahead of a stalled decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          N        = WORD_PC_W      // only 30 is supported
) (
    input  logic          clk,
    input  logic          rst_n,
    // external word-PC incrementer
    output logic [N-1:0]  inc_pc_o,
    input  logic [N-1:0]  inc_res_i,
    // instruction memory
    output logic          imem_req_o,
    output logic [31:0]   imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [31:0]   imem_rdata_i,
    // redirect from execute
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    // decode interface
    output logic          id_valid_o,
    input  logic          id_ready_i,
    output logic [31:0]   id_instr_o,
    output logic [31:0]   id_pc_o,
    output logic [31:0]   id_pc4_o
);

    fetch_state_t  r_state;
    logic [N-1:0]  r_pc_word;
    logic          r_req_hold;      // request shown last cycle, not yet granted
    logic [31:0]   r_pend_pc;       // address of the outstanding request
    logic [31:0]   r_pend_pc4;      // that address + 4, taken from the incrementer
    logic          r_id_valid;
    fetch_entry_t  r_id_entry;

    logic          w_room;          // a new request's response will have a slot
    logic          w_out_free;      // output register empties (or is empty) this cycle
    logic          w_resp;          // a live response is accepted this cycle
    logic          w_issue_gnt;     // request handed to memory this cycle
    logic          w_skid_valid;
    fetch_entry_t  w_skid_data;
    fetch_entry_t  w_resp_entry;
    logic          w_unused_low_bits;

    // Redirect targets are word aligned; the low bits carry no information
    assign w_unused_low_bits = ^redirect_pc_i[1:0];

    assign w_out_free   = !r_id_valid || id_ready_i;
    assign w_resp       = (r_state == ST_WAIT) && imem_rvalid_i && !redirect_i;
    assign w_resp_entry = '{instr: imem_rdata_i, pc: r_pend_pc, pc4: r_pend_pc4};

    // A request, once shown, stays up until granted; a new one is only raised
    // when its response is guaranteed somewhere to land. Gated by rst_n so the
    // request is low throughout reset and rises in the first cycle after it.
    assign imem_req_o  = rst_n && (r_state == ST_REQ) && (r_req_hold || w_room);
    assign w_issue_gnt = imem_req_o && imem_gnt_i;

    assign inc_pc_o    = r_pc_word;
    assign imem_addr_o = word_to_addr(r_pc_word);

`ifdef FETCH_SKID_BUF_EN
    logic w_skid_push;
    logic w_skid_pop;

    // Requests stop only when output register and skid entry both stay full
    assign w_room      = !(r_id_valid && w_skid_valid && !id_ready_i);
    // A response goes to the skid entry when the output register is busy
    // next cycle (stalled, or being refilled from the skid entry)
    assign w_skid_push = w_resp && (!w_out_free || w_skid_valid);
    assign w_skid_pop  = !redirect_i && w_out_free && w_skid_valid;

    fetch_skid_buf u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (w_skid_push),
        .push_data (w_resp_entry),
        .pop       (w_skid_pop),
        .valid     (w_skid_valid),
        .data      (w_skid_data)
    );
`else
    // Single output slot: no request while decode holds a stalled instruction
    assign w_room       = !(r_id_valid && !id_ready_i);
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = '0;
`endif

    // Fetch sequencing: PC, request bookkeeping and discard of stale responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc_word  <= RESET_PC[N+1:2];
            r_req_hold <= 1'b0;
            r_pend_pc  <= '0;
            r_pend_pc4 <= '0;
        end else begin
            r_req_hold <= imem_req_o && !imem_gnt_i && !redirect_i;
            if (redirect_i) begin
                // Redirect beats the increment; a granted request with no
                // response yet (including one granted right now) is killed
                r_pc_word <= redirect_pc_i[N+1:2];
                case (r_state)
                    ST_REQ:  r_state <= w_issue_gnt ? ST_KILL : ST_REQ;
                    default: r_state <= imem_rvalid_i ? ST_REQ : ST_KILL;
                endcase
            end else begin
                case (r_state)
                    ST_REQ: begin
                        if (w_issue_gnt) begin
                            r_pc_word  <= inc_res_i;
                            r_pend_pc  <= word_to_addr(r_pc_word);
                            r_pend_pc4 <= {inc_res_i, 2'b00};
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid_i) begin
                            r_state <= ST_REQ;
                        end
                    end
                    ST_KILL: begin
                        if (imem_rvalid_i) begin
                            r_state <= ST_REQ;
                        end
                    end
                    default: r_state <= ST_REQ;
                endcase
            end
        end
    end

    // Decode-facing output register: refill from skid first, then from memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_entry <= '0;
        end else if (redirect_i) begin
            r_id_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                r_id_valid <= 1'b1;
                r_id_entry <= w_skid_data;
            end else if (w_resp) begin
                r_id_valid <= 1'b1;
                r_id_entry <= w_resp_entry;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_valid_o = r_id_valid;
    assign id_instr_o = r_id_entry.instr;
    assign id_pc_o    = r_id_entry.pc;
    assign id_pc4_o   = r_id_entry.pc4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_stage
// Description : Self-checking bench for fetch_pc_stage with a transaction
//               level reference model (next-fetch address, outstanding flag,
//               decode queue) and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
`ifdef FETCH_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] inc_pc_o;
    logic [29:0] inc_res_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;

    always #5 clk = ~clk;

    // External combinational word-PC incrementer
    assign inc_res_i = inc_pc_o + 30'd1;

    fetch_pc_stage #(.RESET_PC(TB_RESET_PC), .N(30)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_pc_o      (inc_pc_o),
        .inc_res_i     (inc_res_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        m_q[$];       // instructions waiting for decode, oldest first
    logic [31:0] m_pc;         // byte address of the next fetch
    bit          m_out;        // one request granted, response not yet seen
    bit          m_killed;     // that response must be thrown away
    logic [31:0] m_oaddr;      // address of the outstanding request
    bit          m_held;       // request shown last cycle and not granted

    int checks = 0;
    int errors = 0;

    // Last observed DUT outputs (sampled mid-cycle inside step)
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_pc4;

    task automatic model_reset();
        m_q.delete();
        m_pc     = TB_RESET_PC & 32'hFFFF_FFFC;
        m_out    = 1'b0;
        m_killed = 1'b0;
        m_oaddr  = '0;
        m_held   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input bit gnt, input bit rv, input bit rdy, input bit redir,
                        input logic [31:0] tgt);
        bit          e_req, e_valid, bad, rv_eff;
        int          occ_after;
        logic [31:0] rd;
        ent_t        e;
        @(negedge clk);
        rd            = $urandom;
        rv_eff        = rv && m_out;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv_eff;
        imem_rdata_i  = rd;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        #2;
        occ_after = m_q.size() - ((m_q.size() > 0 && rdy) ? 1 : 0);
        e_req     = !m_out && (m_held || occ_after < CAP);
        e_valid   = (m_q.size() > 0);
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_valid = id_valid_o;
        obs_pc    = id_pc_o;
        obs_pc4   = id_pc4_o;
        bad = (imem_req_o !== e_req) || (inc_pc_o !== m_pc[31:2]) ||
              (e_req && imem_addr_o !== m_pc) || (id_valid_o !== e_valid);
        if (e_valid)
            bad = bad || (id_instr_o !== m_q[0].instr) || (id_pc_o !== m_q[0].pc) ||
                  (id_pc4_o !== m_q[0].pc4);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle@%0t: req %b exp %b, addr %h exp %h, valid %b exp %b, pc %h exp %h, pc4 %h exp %h, instr %h exp %h",
                     $time, imem_req_o, e_req, imem_addr_o, m_pc, id_valid_o, e_valid,
                     id_pc_o, e_valid ? m_q[0].pc : 32'h0, id_pc4_o, e_valid ? m_q[0].pc4 : 32'h0,
                     id_instr_o, e_valid ? m_q[0].instr : 32'h0);
        end
        @(posedge clk);
        if (redir) begin
            m_q.delete();
            if (e_req && gnt) begin
                m_out = 1'b1;  m_killed = 1'b1;
            end else if (m_out) begin
                if (rv_eff) begin m_out = 1'b0; m_killed = 1'b0; end
                else m_killed = 1'b1;
            end
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_held = 1'b0;
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (rv_eff) begin
                if (!m_killed) begin
                    e.instr = rd;  e.pc = m_oaddr;  e.pc4 = m_oaddr + 32'd4;
                    m_q.push_back(e);
                end
                m_out = 1'b0;  m_killed = 1'b0;
            end
            if (e_req && gnt) begin
                m_out = 1'b1;  m_killed = 1'b0;  m_oaddr = m_pc;  m_pc = m_pc + 32'd4;
            end
            m_held = e_req && !gnt;
        end
    endtask

    task automatic idle_inputs();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        id_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    endtask

    // Release reset between a rising and falling edge so the next step sees
    // the first post-reset cycle
    task automatic release_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Step steady traffic until one instruction waits for decode and nothing
    // is in flight
    task automatic reach_single_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1, 1, 1, 0, 32'h0);
            ok = (m_q.size() == 1) && !m_out && !m_held;
        end
        chk({name, "_reached"}, {31'h0, ok}, 32'h1);
    endtask

    initial begin
        logic [31:0] seen[$];
        logic [31:0] front_pc;
        int          nreq;
        bit          held_ok;

        rst_n = 1'b0;
        idle_inputs();
        model_reset();

        // Reset values
        #12;
        chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_instr", id_instr_o, 32'h0);
        chk("rst_pc",    id_pc_o,    32'h0);
        chk("rst_pc4",   id_pc4_o,   32'h0);
        chk("rst_addr",  imem_addr_o, TB_RESET_PC);
        release_reset();

        // Back-to-back fetches: 0x0, 0x4, 0x8 in order
        step(1, 1, 1, 0, 32'h0);
        chk("first_req",  {31'h0, obs_req}, 32'h1);
        chk("first_addr", obs_addr, TB_RESET_PC);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 0, 32'h0);
            if (obs_valid) begin
                seen.push_back(obs_pc);
                chk("seq_pc4", obs_pc4, obs_pc + 32'd4);
            end
        end
        chk("seq_count_ge3", {31'h0, seen.size() >= 3}, 32'h1);
        if (seen.size() >= 3) begin
            chk("seq_pc0", seen[0], 32'h0000_0000);
            chk("seq_pc1", seen[1], 32'h0000_0004);
            chk("seq_pc2", seen[2], 32'h0000_0008);
        end

        // Decode stall for 5 cycles: outputs held, bounded extra requests
        reach_single_valid("stall");
        front_pc = (m_q.size() > 0) ? m_q[0].pc : 32'hDEAD_BEEF;
        nreq = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 32'h0);
            nreq += int'(obs_req);
            if (!(obs_valid === 1'b1 && obs_pc === front_pc)) held_ok = 1'b0;
        end
        chk("stall_held", {31'h0, held_ok}, 32'h1);
        chk("stall_reqs", nreq, CAP - 1);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 32'h0);

        // Redirect to 0x1002 while waiting for a response
        for (int i = 0; i < 10 && !m_out; i++) step(1, 0, 1, 0, 32'h0);
        chk("wait_reached", {31'h0, m_out}, 32'h1);
        step(0, 0, 1, 1, 32'h0000_1002);
        step(0, 1, 1, 0, 32'h0);
        chk("kill_no_valid", {31'h0, obs_valid}, 32'h0);
        chk("kill_no_req",   {31'h0, obs_req},   32'h0);
        step(1, 0, 1, 0, 32'h0);
        chk("redir_valid_clear", {31'h0, obs_valid}, 32'h0);
        chk("redir_req",  {31'h0, obs_req}, 32'h1);
        chk("redir_addr", obs_addr, 32'h0000_1000);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        chk("redir_id_pc",  obs_pc,  32'h0000_1000);
        chk("redir_id_pc4", obs_pc4, 32'h0000_1004);

        // PC wrap at the top of the address space
        step(0, 0, 1, 1, 32'hFFFF_FFFE);
        step(0, 1, 1, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        chk("wrap_req",  {31'h0, obs_req}, 32'h1);
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        chk("wrap_addr1", obs_addr, 32'h0000_0000);
        chk("wrap_id_pc",  obs_pc,  32'hFFFF_FFFC);
        chk("wrap_id_pc4", obs_pc4, 32'h0000_0000);

        // Redirect together with grant and decode transfer
        reach_single_valid("combo");
        step(1, 0, 1, 1, 32'h0000_2000);
        chk("combo_granted",  {31'h0, obs_req},   32'h1);
        chk("combo_transfer", {31'h0, obs_valid}, 32'h1);
        step(0, 1, 1, 0, 32'h0);
        chk("combo_kill_valid", {31'h0, obs_valid}, 32'h0);
        chk("combo_kill_req",   {31'h0, obs_req},   32'h0);
        step(1, 0, 1, 0, 32'h0);
        chk("combo_addr", obs_addr, 32'h0000_2000);
        step(0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        chk("combo_id_pc", obs_pc, 32'h0000_2000);

        // Asynchronous reset while a response is outstanding
        for (int i = 0; i < 10 && !m_out; i++) step(1, 0, 1, 0, 32'h0);
        chk("arst_wait_reached", {31'h0, m_out}, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'h0, imem_req_o}, 32'h0);
        chk("arst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("arst_instr", id_instr_o,  32'h0);
        chk("arst_pc",    id_pc_o,     32'h0);
        chk("arst_pc4",   id_pc4_o,    32'h0);
        chk("arst_addr",  imem_addr_o, 32'h0);
        model_reset();
        @(posedge clk);
        release_reset();
        step(1, 0, 1, 0, 32'h0);
        chk("arst_first_req",  {31'h0, obs_req}, 32'h1);
        chk("arst_first_addr", obs_addr, TB_RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          g, r, y, d;
            logic [31:0] t;
            g = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 45);
            y = ($urandom_range(0, 99) < ((i % 400) < 200 ? 70 : 25));
            d = ($urandom_range(0, 99) < 5);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : $urandom;
            step(g, r, y, d, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_stage.md
FETCH_PC_STAGE -- requirements
Module: fetch_pc_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have parameter N, default 30, word-PC width; N = 30 is the only supported value.
REQ-003 SHALL be clocked by one clock and reset asynchronously, active-low: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 inc_pc_o  out  N  word PC (pc[31:2]) driven to the combinational word-PC incrementer.
REQ-006 inc_res_i  in  N  incrementer result, inc_pc_o + 1 mod 2^N.
REQ-007 imem_req_o  out  1  instruction-memory request valid.
REQ-008 imem_addr_o  out  32  request address, {pc_word, 2'b00}.
REQ-009 imem_gnt_i  in  1  request accepted this cycle.
REQ-010 imem_rvalid_i  in  1  response data valid.
REQ-011 imem_rdata_i  in  32  instruction word.
REQ-012 redirect_i  in  1  branch/jump redirect from execute.
REQ-013 redirect_pc_i  in  32  redirect target; bits [1:0] ignored.
REQ-014 id_valid_o  out  1  fetched instruction valid toward decode.
REQ-015 id_ready_i  in  1  decode accepts this cycle.
REQ-016 id_instr_o  out  32  instruction; id_pc_o out 32, its address; id_pc4_o out 32, id_pc_o + 4.

Function
REQ-017 SHALL use states REQ (imem_req_o=1), WAIT (one request outstanding), KILL (outstanding response to discard).
REQ-018 REQ->WAIT on imem_gnt_i; pc_word loads inc_res_i on the same edge.
REQ-019 WAIT: on imem_rvalid_i, capture rdata, request address, address+4 into output register, id_valid_o=1 next cycle; go to REQ if output slot free after this cycle, else stay stalled (no request) until id_ready_i.
REQ-020 Output transfer occurs when id_valid_o && id_ready_i; id_* SHALL hold stable while id_valid_o && !id_ready_i.
REQ-021 At most one outstanding imem request; imem_req_o SHALL stay high and imem_addr_o stable until gnt.
REQ-022 redirect_i (any state): pc_word loads redirect_pc_i[31:2] next edge, id_valid_o clears next edge; state REQ, or KILL if a granted response is outstanding (including gnt in the same cycle).
REQ-023 KILL: drop the next imem_rvalid_i response, then go to REQ at the new pc_word.
REQ-024 redirect_i has priority over gnt-driven PC increment and over id transfer in the same cycle.
REQ-025 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 silently.
REQ-026 id_pc4_o SHALL be {inc_res_i, 2'b00} captured at request time.

Reset
REQ-027 While rst_n=0: state REQ, pc_word=RESET_PC[31:2], imem_req_o=0, id_valid_o=0, id_instr_o=id_pc_o=id_pc4_o=0.
REQ-028 First imem_req_o=1 in the first cycle after rst_n deasserts; reset mid-request abandons outstanding responses.

Configuration
REQ-029 Macro FETCH_SKID_BUF_EN SHALL add a one-entry skid buffer behind the output register.
REQ-030 With it: a new request issues while output is stalled; a response arriving while output is full goes to the buffer; requests stop only when both are full; redirect clears both.
REQ-031 Without it: no request issues while id_valid_o && !id_ready_i.

Structure
REQ-032 A shared package SHALL hold the state enum, RESET_PC default, and WORD_PC_W = 30.
REQ-033 The skid buffer SHALL be a sub-module fetch_skid_buf; the incrementer stays external.

Verification
REQ-034 Reset release, gnt and rvalid always high -> addresses 0x0,0x4,0x8 in order; id_pc4_o = id_pc_o+4.
REQ-035 id_ready_i=0 for 5 cycles -> id_* held; no imem_req_o without macro; exactly one extra request with macro.
REQ-036 redirect_i to 0x0000_1002 while in WAIT -> stale response dropped, next imem_addr_o=0x0000_1000, no stale id_valid_o.
REQ-037 pc_word=30'h3FFF_FFFF granted -> next imem_addr_o=0x0000_0000.
REQ-038 rst_n low while WAIT -> all outputs 0 asynchronously; after release, first address is RESET_PC.
REQ-039 Redirect in same cycle as gnt and id transfer -> target fetched next, granted response killed.
